sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences the single external 128K x 8 SRAM and shares it between two requesters: the video fetch path (reads) and the MCU pixel-write path (writes).
- Video reads have priority, with bounded starvation protection for MCU writes.
- MCU writes are buffered in a small FIFO, so bus-side register writes never stall on video traffic.
- Sits between the video/MCU front ends and the top-level SRAM pins; the top level builds the tristate data bus from ramDataOut/ramDataOutEnable.

Parameters:
- READ_CYCLES, 2, clocks OE is held low per read (1..15).
- WRITE_CYCLES, 2, clocks WE is held low per write (1..15).
- FIFO_DEPTH, 4, MCU write FIFO entries (power of two, 2..16).
- MAX_VIDEO_STREAK, 8, maximum consecutive video grants while an MCU write waits.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- videoReadRequest  in  1  one-cycle read request pulse
- videoReadAddress  in  17  read address, sampled with videoReadRequest
- videoReadData  out  8  registered read data
- videoReadValid  out  1  one-cycle pulse: videoReadData valid
- videoBusy  out  1  a video read is pending or in progress
- videoOverrun  out  1  sticky: request arrived while videoBusy
- mcuWriteValid  in  1  write entry offered
- mcuWriteAddress  in  17  write address
- mcuWriteData  in  8  write data
- mcuWriteReady  out  1  FIFO not full; push = mcuWriteValid & mcuWriteReady
- mcuWriteComplete  out  1  one-cycle pulse per finished SRAM write
- mcuFifoCount  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ramAddress  out  17  SRAM address
- ramDataOut  out  8  SRAM write data
- ramDataOutEnable  out  1  drive data bus
- ramDataIn  in  8  SRAM data bus input
- ramWriteEnable  out  1  SRAM /WE, active low
- ramOutputEnable  out  1  SRAM /OE, active low

Behaviour:
- Reset (reset==0 at an edge) forces, even mid-operation:
  - FSM to IDLE; FIFO emptied; streak counter cleared; pending read dropped.
  - ramWriteEnable=1, ramOutputEnable=1, ramDataOutEnable=0, ramAddress=0, ramDataOut=0.
  - videoReadData=0, videoReadValid=0, videoBusy=0, videoOverrun=0, mcuWriteComplete=0.
  - mcuWriteReady=1, mcuFifoCount=0.
- All outputs are registered, except mcuWriteReady and mcuFifoCount, which derive from FIFO state registers.
- Video capture:
  - A request sampled at edge N while videoBusy=0 latches the address and sets videoBusy from N.
  - A request while videoBusy=1 is dropped and sets videoOverrun.
  - videoBusy clears on the edge that raises videoReadValid.
- FSM states: IDLE, READ, WRITE_SETUP, WRITE_PULSE, WRITE_HOLD.
- IDLE grant rule, evaluated on each edge:
  - Pending read and (streak<MAX_VIDEO_STREAK or FIFO empty) -> READ. The streak increments if the FIFO is non-empty, otherwise clears.
  - Otherwise, FIFO non-empty -> WRITE_SETUP. Pop the head, clear the streak.
  - Otherwise stay in IDLE.
- READ:
  - ramAddress = latched address; ramOutputEnable=0 for exactly READ_CYCLES cycles.
  - ramDataIn is sampled on the edge ending the last cycle into videoReadData; videoReadValid=1 for the following cycle.
  - Return to IDLE on that edge.
  - Latency: request at edge N -> READ entered at N+1 -> valid asserted at edge N+1+READ_CYCLES.
- WRITE_SETUP (1 cycle): ramAddress and ramDataOut = popped entry; ramDataOutEnable=1; WE=1.
- WRITE_PULSE (WRITE_CYCLES cycles): same drive, WE=0.
- WRITE_HOLD (1 cycle): WE=1, data still driven; mcuWriteComplete=1 this cycle; then IDLE with ramDataOutEnable=0.
- OE and WE are never low in the same cycle. ramDataOutEnable=1 only in write states.
- FIFO rules:
  - mcuWriteReady reflects registered full status; a push while full is refused, even if a pop occurs on the same edge.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Address width: 17 bits, no arithmetic performed.

Test Plan:
- Reset then idle: all outputs at reset values; mcuWriteReady=1; no OE/WE activity for 20 cycles.
- Single video read, addr 0x1ABCD, SRAM model returns 0x5A: OE low exactly 2 cycles; videoReadValid at request edge+3; videoReadData=0x5A.
- Push 4 writes (0x00010..0x00013, data 1..4): FIFO fills; a 5th offer sees mcuWriteReady=0. SRAM receives 4 writes in order, each a 1+2+1 cycle sequence with 4 mcuWriteComplete pulses; count returns to 0.
- Back-to-back video requests every READ_CYCLES+1 cycles with 1 write queued: exactly 8 reads granted, then the write, then reads resume; no overrun.
- Video request while videoBusy: videoOverrun=1 and stays 1; the second read is never issued.
- Assert reset mid WRITE_PULSE: WE=1 and ramDataOutEnable=0 on the next edge; FIFO count 0; no mcuWriteComplete.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: video read, MCU write FIFO and SRAM pin signals of the SRAM arbiter
interface sram_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                        videoReadRequest;
  logic [16:0]                 videoReadAddress;
  logic [7:0]                  videoReadData;
  logic                        videoReadValid;
  logic                        videoBusy;
  logic                        videoOverrun;
  logic                        mcuWriteValid;
  logic [16:0]                 mcuWriteAddress;
  logic [7:0]                  mcuWriteData;
  logic                        mcuWriteReady;
  logic                        mcuWriteComplete;
  logic [$clog2(FIFO_DEPTH):0] mcuFifoCount;
  logic [16:0]                 ramAddress;
  logic [7:0]                  ramDataOut;
  logic                        ramDataOutEnable;
  logic [7:0]                  ramDataIn;
  logic                        ramWriteEnable;
  logic                        ramOutputEnable;
  modport slave (
    input  videoReadRequest, videoReadAddress, mcuWriteValid, mcuWriteAddress, mcuWriteData, ramDataIn,
    output videoReadData, videoReadValid, videoBusy, videoOverrun, mcuWriteReady, mcuWriteComplete,
    output mcuFifoCount, ramAddress, ramDataOut, ramDataOutEnable, ramWriteEnable, ramOutputEnable
  );
  modport master (
    output videoReadRequest, videoReadAddress, mcuWriteValid, mcuWriteAddress, mcuWriteData, ramDataIn,
    input  videoReadData, videoReadValid, videoBusy, videoOverrun, mcuWriteReady, mcuWriteComplete,
    input  mcuFifoCount, ramAddress, ramDataOut, ramDataOutEnable, ramWriteEnable, ramOutputEnable
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 128Kx8 SRAM between prioritised video reads and FIFO-buffered MCU writes
module sram_arbiter #(
  parameter int unsigned READ_CYCLES      = 2,
  parameter int unsigned WRITE_CYCLES     = 2,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned MAX_VIDEO_STREAK = 8
) (
  input logic           clock,
  input logic           reset,
  sram_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = $clog2(MAX_VIDEO_STREAK + 1);
  typedef enum logic [2:0] {IDLE, READ, WRITE_SETUP, WRITE_PULSE, WRITE_HOLD} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q, count_d;
  logic          busy_q, busy_d, ovr_q, ovr_d, valid_q, valid_d, cmpl_q, cmpl_d;
  logic [16:0]   rd_addr_q, rd_addr_d, addr_q, addr_d;
  logic [7:0]    rdata_q, rdata_d, dout_q, dout_d;
  logic          doe_q, doe_d, we_q, we_d, oe_q, oe_d;
  logic          empty, full, push, pop, done, accept, grant_rd;
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == (AW+1)'(FIFO_DEPTH);
    push     = bus.mcuWriteValid && !full;
    done     = state_q == READ && cnt_q == '0;
    // the completing edge frees the read slot, so a request there is taken, not an overrun
    accept   = bus.videoReadRequest && (!busy_q || done);
    grant_rd = state_q == IDLE && busy_q && (streak_q < SW'(MAX_VIDEO_STREAK) || empty);
    pop      = state_q == IDLE && !grant_rd && !empty;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = grant_rd ? READ : pop ? WRITE_SETUP : IDLE;
        cnt_d   = 4'(READ_CYCLES - 1);
      end
      READ: begin
        state_d = done ? IDLE : READ;
        cnt_d   = cnt_q - 1'b1;
      end
      WRITE_SETUP: begin
        state_d = WRITE_PULSE;
        cnt_d   = 4'(WRITE_CYCLES - 1);
      end
      WRITE_PULSE: begin
        state_d = cnt_q == '0 ? WRITE_HOLD : WRITE_PULSE;
        cnt_d   = cnt_q - 1'b1;
      end
      WRITE_HOLD: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  // pin-side outputs are registered from the next state so they line up with it
  always_comb begin
    streak_d  = grant_rd ? (empty ? '0 : streak_q + 1'b1) : pop ? '0 : streak_q;
    count_d   = push && !pop ? count_q + 1'b1 : pop && !push ? count_q - 1'b1 : count_q;
    busy_d    = accept || (busy_q && !done);
    rd_addr_d = accept ? bus.videoReadAddress : rd_addr_q;
    ovr_d     = ovr_q || (bus.videoReadRequest && !accept);
    valid_d   = done;
    rdata_d   = done ? bus.ramDataIn : rdata_q;
    addr_d    = grant_rd ? rd_addr_q : pop ? mem_q[rp_q][24:8] : addr_q;
    dout_d    = pop ? mem_q[rp_q][7:0] : dout_q;
    oe_d      = state_d != READ;
    we_d      = state_d != WRITE_PULSE;
    doe_d     = state_d inside {WRITE_SETUP, WRITE_PULSE, WRITE_HOLD};
    cmpl_d    = state_d == WRITE_HOLD;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      streak_q  <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      cmpl_q    <= 1'b0;
      rd_addr_q <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      dout_q    <= '0;
      doe_q     <= 1'b0;
      we_q      <= 1'b1;
      oe_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      wp_q      <= wp_q + AW'(push);
      rp_q      <= rp_q + AW'(pop);
      count_q   <= count_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      cmpl_q    <= cmpl_d;
      rd_addr_q <= rd_addr_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q] <= {bus.mcuWriteAddress, bus.mcuWriteData};
  end
  assign bus.videoReadData    = rdata_q;
  assign bus.videoReadValid   = valid_q;
  assign bus.videoBusy        = busy_q;
  assign bus.videoOverrun     = ovr_q;
  assign bus.mcuWriteReady    = !full;
  assign bus.mcuWriteComplete = cmpl_q;
  assign bus.mcuFifoCount     = count_q;
  assign bus.ramAddress       = addr_q;
  assign bus.ramDataOut       = dout_q;
  assign bus.ramDataOutEnable = doe_q;
  assign bus.ramWriteEnable   = we_q;
  assign bus.ramOutputEnable  = oe_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven vectors plus directed multi-cycle sequences for sram_arbiter
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  sram_arbiter_if #(.FIFO_DEPTH(4)) bus ();
  sram_arbiter #(.READ_CYCLES(2), .WRITE_CYCLES(2), .FIFO_DEPTH(4), .MAX_VIDEO_STREAK(8)) dut (
    .clock(clk), .reset(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  // SRAM model: one fixed location, everything else a simple address pattern
  assign bus.ramDataIn = bus.ramAddress == 17'h1ABCD ? 8'h5A : bus.ramAddress[7:0] ^ 8'h3C;
  typedef struct packed {
    logic oe, we, doe;
    logic [16:0] ra;
    logic [7:0] rdo;
    logic valid;
    logic [7:0] rdata;
    logic busy, ovr, ready;
    logic [2:0] cnt;
    logic cmpl;
  } out_t;
  typedef struct {
    logic rst_n, req;
    logic [16:0] addr;
    logic wv;
    logic [16:0] wa;
    logic [7:0] wd;
    out_t exp;
  } vec_t;
  function automatic out_t o(input logic oe, input logic we, input logic doe, input logic [16:0] ra,
                             input logic [7:0] rdo, input logic valid, input logic [7:0] rdata,
                             input logic busy, input logic ovr, input logic ready, input logic [2:0] cnt,
                             input logic cmpl);
    return '{oe, we, doe, ra, rdo, valid, rdata, busy, ovr, ready, cnt, cmpl};
  endfunction
  function automatic out_t act();
    return o(bus.ramOutputEnable, bus.ramWriteEnable, bus.ramDataOutEnable, bus.ramAddress, bus.ramDataOut,
             bus.videoReadValid, bus.videoReadData, bus.videoBusy, bus.videoOverrun, bus.mcuWriteReady,
             bus.mcuFifoCount, bus.mcuWriteComplete);
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  int n_rd = 0, n_wr = 0, we_lo = 0, doe_hi = 0, n_cmpl = 0, n_valid = 0, n_both = 0;
  logic [16:0] w_addr [64];
  logic [7:0] w_data [64];
  int w_rd [64];
  logic p_we = 1'b1, p_oe = 1'b1;
  always @(negedge clk) begin
    if (!bus.ramOutputEnable && p_oe) n_rd <= n_rd + 1;
    if (!bus.ramWriteEnable && p_we && n_wr < 64) begin
      w_addr[n_wr] <= bus.ramAddress;
      w_data[n_wr] <= bus.ramDataOut;
      w_rd[n_wr] <= n_rd;
      n_wr <= n_wr + 1;
    end
    we_lo <= we_lo + int'(!bus.ramWriteEnable);
    doe_hi <= doe_hi + int'(bus.ramDataOutEnable);
    n_cmpl <= n_cmpl + int'(bus.mcuWriteComplete);
    n_valid <= n_valid + int'(bus.videoReadValid);
    n_both <= n_both + int'(!bus.ramWriteEnable && !bus.ramOutputEnable);
    p_we <= bus.ramWriteEnable;
    p_oe <= bus.ramOutputEnable;
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.videoReadRequest = 1'b0;
    bus.mcuWriteValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  vec_t tv [17];
  int rd0, wr0, we0, doe0, c0, v0, t;
  logic flag;
  initial begin
    bus.videoReadRequest = 1'b0;
    bus.videoReadAddress = '0;
    bus.mcuWriteValid = 1'b0;
    bus.mcuWriteAddress = '0;
    bus.mcuWriteData = '0;
    tv[0]  = '{1'b0, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,0,17'h0,    8'h0, 0,8'h0, 0,0,1,3'd0,0)};
    tv[1]  = '{1'b1, 1'b1, 17'h1ABCD, 1'b0, 17'h0,  8'h0,  o(1,1,0,17'h0,    8'h0, 0,8'h0, 1,0,1,3'd0,0)};
    tv[2]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(0,1,0,17'h1ABCD,8'h0, 0,8'h0, 1,0,1,3'd0,0)};
    tv[3]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(0,1,0,17'h1ABCD,8'h0, 0,8'h0, 1,0,1,3'd0,0)};
    tv[4]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,0,17'h1ABCD,8'h0, 1,8'h5A,0,0,1,3'd0,0)};
    tv[5]  = '{1'b1, 1'b0, 17'h0,     1'b1, 17'h10, 8'h11, o(1,1,0,17'h1ABCD,8'h0, 0,8'h5A,0,0,1,3'd1,0)};
    tv[6]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,1,17'h10,   8'h11,0,8'h5A,0,0,1,3'd0,0)};
    tv[7]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,0,1,17'h10,   8'h11,0,8'h5A,0,0,1,3'd0,0)};
    tv[8]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,0,1,17'h10,   8'h11,0,8'h5A,0,0,1,3'd0,0)};
    tv[9]  = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,1,17'h10,   8'h11,0,8'h5A,0,0,1,3'd0,1)};
    tv[10] = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,0,17'h10,   8'h11,0,8'h5A,0,0,1,3'd0,0)};
    tv[11] = '{1'b1, 1'b1, 17'h42,    1'b1, 17'h20, 8'h22, o(1,1,0,17'h10,   8'h11,0,8'h5A,1,0,1,3'd1,0)};
    tv[12] = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(0,1,0,17'h42,   8'h11,0,8'h5A,1,0,1,3'd1,0)};
    tv[13] = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(0,1,0,17'h42,   8'h11,0,8'h5A,1,0,1,3'd1,0)};
    tv[14] = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,0,17'h42,   8'h11,1,8'h7E,0,0,1,3'd1,0)};
    tv[15] = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,1,1,17'h20,   8'h22,0,8'h7E,0,0,1,3'd0,0)};
    tv[16] = '{1'b1, 1'b0, 17'h0,     1'b0, 17'h0,  8'h0,  o(1,0,1,17'h20,   8'h22,0,8'h7E,0,0,1,3'd0,0)};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst_n = tv[i].rst_n;
      bus.videoReadRequest = tv[i].req;
      bus.videoReadAddress = tv[i].addr;
      bus.mcuWriteValid = tv[i].wv;
      bus.mcuWriteAddress = tv[i].wa;
      bus.mcuWriteData = tv[i].wd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), act(), tv[i].exp);
    end
    // idle after reset: outputs hold their reset values
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), act(), o(1,1,0,17'h0,8'h0,0,8'h0,0,0,1,3'd0,0));
    end
    // FIFO fill behind a read, refused push while full, in-order drain
    do_reset();
    rd0 = n_rd; wr0 = n_wr; we0 = we_lo; doe0 = doe_hi; c0 = n_cmpl; v0 = n_valid;
    @(negedge clk);
    bus.videoReadRequest = 1'b1; bus.videoReadAddress = 17'h300;
    bus.mcuWriteValid = 1'b1; bus.mcuWriteAddress = 17'h10; bus.mcuWriteData = 8'd1;
    @(negedge clk);
    bus.videoReadRequest = 1'b0; bus.mcuWriteAddress = 17'h11; bus.mcuWriteData = 8'd2;
    @(negedge clk);
    bus.mcuWriteAddress = 17'h12; bus.mcuWriteData = 8'd3;
    @(negedge clk);
    bus.mcuWriteAddress = 17'h13; bus.mcuWriteData = 8'd4;
    @(negedge clk);
    chk("full_ready", bus.mcuWriteReady, 0);
    chk("full_count", bus.mcuFifoCount, 4);
    bus.mcuWriteAddress = 17'h14; bus.mcuWriteData = 8'd5;
    @(negedge clk);
    chk("refused_count", bus.mcuFifoCount, 3);
    chk("ready_again", bus.mcuWriteReady, 1);
    bus.mcuWriteValid = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;
    chk("fill_writes", n_wr - wr0, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill_addr%0d", k), w_addr[wr0+k], 17'h10 + k);
      chk($sformatf("fill_data%0d", k), w_data[wr0+k], k + 1);
    end
    chk("fill_we_cycles", we_lo - we0, 8);
    chk("fill_doe_cycles", doe_hi - doe0, 16);
    chk("fill_complete", n_cmpl - c0, 4);
    chk("fill_count_end", bus.mcuFifoCount, 0);
    chk("fill_reads", n_valid - v0, 1);
    chk("fill_rdata", bus.videoReadData, 8'h3C);
    // streak limit: 8 reads, then the waiting write, then reads resume
    do_reset();
    rd0 = n_rd; wr0 = n_wr; v0 = n_valid;
    @(negedge clk);
    bus.videoReadRequest = 1'b1; bus.videoReadAddress = 17'h200;
    bus.mcuWriteValid = 1'b1; bus.mcuWriteAddress = 17'h100; bus.mcuWriteData = 8'h77;
    @(negedge clk);
    bus.videoReadRequest = 1'b0; bus.mcuWriteValid = 1'b0;
    for (int i = 1; i < 12; i++) begin
      t = 0;
      while (bus.ramOutputEnable && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("grant_wait%0d", i), t < 50, 1);
      @(negedge clk);
      bus.videoReadRequest = 1'b1; bus.videoReadAddress = 17'h200 + 17'(i);
      @(negedge clk);
      bus.videoReadRequest = 1'b0;
    end
    t = 0;
    while (bus.videoBusy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("streak_drain", t < 50, 1);
    @(posedge clk);
    #1;
    chk("streak_reads", n_rd - rd0, 12);
    chk("streak_valids", n_valid - v0, 12);
    chk("streak_writes", n_wr - wr0, 1);
    chk("streak_before_write", w_rd[wr0] - rd0, 8);
    chk("streak_waddr", w_addr[wr0], 17'h100);
    chk("streak_overrun", bus.videoOverrun, 0);
    // request while busy: sticky overrun, second read never issued
    do_reset();
    rd0 = n_rd; v0 = n_valid;
    @(negedge clk);
    bus.videoReadRequest = 1'b1; bus.videoReadAddress = 17'h55;
    @(negedge clk);
    bus.videoReadAddress = 17'h66;
    @(negedge clk);
    bus.videoReadRequest = 1'b0;
    chk("ovr_set", bus.videoOverrun, 1);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", bus.videoOverrun, 1);
    chk("ovr_rdata", bus.videoReadData, 8'h69);
    @(posedge clk);
    #1;
    chk("ovr_reads", n_rd - rd0, 1);
    chk("ovr_valids", n_valid - v0, 1);
    // reset during the WE pulse
    do_reset();
    @(negedge clk);
    bus.mcuWriteValid = 1'b1; bus.mcuWriteAddress = 17'h40; bus.mcuWriteData = 8'hAA;
    @(negedge clk);
    bus.mcuWriteAddress = 17'h41; bus.mcuWriteData = 8'hBB;
    @(negedge clk);
    bus.mcuWriteValid = 1'b0;
    t = 0;
    while (bus.ramWriteEnable && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("pulse_wait", t < 20, 1);
    chk("pulse_count", bus.mcuFifoCount, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_we", bus.ramWriteEnable, 1);
    chk("rst_doe", bus.ramDataOutEnable, 0);
    chk("rst_count", bus.mcuFifoCount, 0);
    chk("rst_ready", bus.mcuWriteReady, 1);
    chk("rst_cmpl", bus.mcuWriteComplete, 0);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mcuWriteComplete || !bus.ramWriteEnable) flag = 1'b1;
    end
    chk("rst_no_write", flag, 0);
    @(posedge clk);
    #1;
    chk("oe_we_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
